// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcodes, FSM state type, default width.
package alu_pkg;

  localparam int unsigned ALU_W_DEF = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; shift amount uses the full B operand, so B >= W saturates the shift.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W_DEF
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_op,
  output logic [W-1:0] o_c
);

  always_comb begin
    o_c = '0;
    case (i_op)
      ALU_ADD: o_c = i_a + i_b;
      ALU_SUB: o_c = i_a - i_b;
      ALU_AND: o_c = i_a & i_b;
      ALU_OR:  o_c = i_a | i_b;
      ALU_SRL: o_c = i_a >> i_b;
      ALU_SRA: o_c = $unsigned($signed(i_a) >>> i_b);
      default: o_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters; the result is
// registered and held until the owning requester completes its response handshake.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W    = ALU_W_DEF,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic [2:0]      req0_op,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [W-1:0]    rsp0_c,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic [2:0]      req1_op,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [W-1:0]    rsp1_c,
  output logic            busy,
  output logic [CNTW-1:0] done0,
  output logic [CNTW-1:0] done1
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_prio;
  logic            r_owner;
  logic [W-1:0]    r_result;
  logic [CNTW-1:0] r_done0;
  logic [CNTW-1:0] r_done1;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_accept;
  logic            w_rsp_hs;
  logic [W-1:0]    w_alu_a;
  logic [W-1:0]    w_alu_b;
  logic [2:0]      w_alu_op;
  logic [W-1:0]    w_alu_c;

  // prio=0 favours requester 0 on contention, prio=1 favours requester 1
  assign w_grant0 = req0_valid & (~req1_valid | ~r_prio);
  assign w_grant1 = req1_valid & (~req0_valid |  r_prio);
  assign w_accept = (r_state == IDLE) & (w_grant0 | w_grant1);
  assign w_rsp_hs = (r_state == RESP) & (r_owner ? rsp1_ready : rsp0_ready);

  assign w_alu_a  = w_grant1 ? req1_a  : req0_a;
  assign w_alu_b  = w_grant1 ? req1_b  : req0_b;
  assign w_alu_op = w_grant1 ? req1_op : req0_op;

  alu #(.W(W)) u_alu (
    .i_a  (w_alu_a),
    .i_b  (w_alu_b),
    .i_op (w_alu_op),
    .o_c  (w_alu_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = rst_n & (r_state == IDLE) & w_grant0;
    req1_ready = rst_n & (r_state == IDLE) & w_grant1;
    busy       = (r_state == RESP);
    rsp0_valid = (r_state == RESP) & ~r_owner;
    rsp1_valid = (r_state == RESP) &  r_owner;
    rsp0_c     = r_result;
    rsp1_c     = r_result;
    done0      = r_done0;
    done1      = r_done1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_result <= '0;
      r_done0  <= '0;
      r_done1  <= '0;
    end else begin
      if (w_accept) begin
        r_result <= w_alu_c;
        r_owner  <= w_grant1;
        r_prio   <= ~w_grant1;
      end
      if (w_rsp_hs) begin
        if (r_owner) r_done1 <= r_done1 + 1'b1;
        else         r_done0 <= r_done0 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed transactions push expected responses,
// a negedge monitor pops and compares them at each response handshake.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned W    = 32;
  localparam int unsigned CNTW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [W-1:0]    req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]      req0_op = '0, req1_op = '0;
  logic            rsp0_valid, rsp1_valid;
  logic            rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [W-1:0]    rsp0_c, rsp1_c;
  logic            busy;
  logic [CNTW-1:0] done0, done1;

  typedef struct {
    int          id;
    logic [31:0] c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  alu_arbiter #(.W(W), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
    .busy(busy), .done0(done0), .done1(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic handle(input int id, input logic [31:0] c, input logic other_valid);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_rsp actual=rsp%0d:0x%08h required=none", id, c);
    end else begin
      e = q.pop_front();
      check("rsp_owner", id, e.id);
      check("rsp_c", c, e.c);
      check("rsp_other_valid", {31'b0, other_valid}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid && rsp0_ready) handle(0, rsp0_c, rsp1_valid);
      if (rsp1_valid && rsp1_ready) handle(1, rsp1_c, rsp0_valid);
    end
  end

  function automatic logic ready_of(input int id);
    return (id == 1) ? req1_ready : req0_ready;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("wait_idle");
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] exp,
                       input bit push, input bit wait_done, output int waited);
    int n = 0;
    @(posedge clk);
    #1;
    if (id == 1) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    if (push) q.push_back('{id, exp});
    @(negedge clk);
    while (!ready_of(id) && n < 20) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!ready_of(id)) fail_now("req_ready_wait");
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (wait_done) wait_idle();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] c;
  } vec_t;

  initial begin
    int   w;
    int   g[5];
    vec_t vecs[6];

    // reset state
    #2;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    check("reset_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    check("reset_done0", {24'b0, done0}, 32'd0);
    check("reset_done1", {24'b0, done1}, 32'd0);
    do_reset();

    // single add on requester 0
    rsp0_ready = 1'b1;
    issue(0, 32'd5, 32'd3, ALU_ADD, 32'd8, 1'b1, 1'b0, w);
    check("t1_ready_same_cycle", w, 0);
    @(negedge clk);
    check("t1_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    check("t1_rsp0_c", rsp0_c, 32'd8);
    wait_idle();
    check("t1_done0", {24'b0, done0}, 32'd1);

    // continuous contention from reset: grants 0,1,0
    do_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    q.push_back('{0, 32'd2});
    q.push_back('{1, 32'hFFFF_FFFF});
    q.push_back('{0, 32'd2});
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = ALU_ADD;
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd1; req1_op = ALU_SUB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      g[i] = req0_ready ? 0 : (req1_ready ? 1 : -1);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("t2_grant0", g[0], 0);
    check("t2_grant_gap0", g[1], -1);
    check("t2_grant1", g[2], 1);
    check("t2_grant_gap1", g[3], -1);
    check("t2_grant2", g[4], 0);
    check("t2_done0", {24'b0, done0}, 32'd2);
    check("t2_done1", {24'b0, done1}, 32'd1);

    // held result on requester 1 with back-pressure
    rsp1_ready = 1'b0;
    issue(1, 32'h8000_0000, 32'd4, ALU_SRA, 32'hF800_0000, 1'b1, 1'b0, w);
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_op = ALU_ADD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_rsp1_c_hold", rsp1_c, 32'hF800_0000);
      check("t3_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      check("t3_busy", {31'b0, busy}, 32'd1);
      check("t3_req0_ready_low", {31'b0, req0_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    wait_idle();
    check("t3_done1", {24'b0, done1}, 32'd2);

    // shift edges, unused opcode, logic ops, subtraction wrap
    vecs[0] = '{32'hFFFF_FFFF, 32'd40,     ALU_SRL, 32'h0000_0000};
    vecs[1] = '{32'hFFFF_FFFF, 32'd40,     ALU_SRA, 32'hFFFF_FFFF};
    vecs[2] = '{32'd5,         32'd3,      3'b111,  32'h0000_0000};
    vecs[3] = '{32'h0000_F0F0, 32'h0000_FF00, ALU_AND, 32'h0000_F000};
    vecs[4] = '{32'h0000_F0F0, 32'h0000_FF00, ALU_OR,  32'h0000_FFF0};
    vecs[5] = '{32'd3,         32'd5,      ALU_SUB, 32'hFFFF_FFFE};
    foreach (vecs[i]) issue(0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].c, 1'b1, 1'b1, w);
    check("t4_done0", {24'b0, done0}, 32'd8);

    // reset during RESP drops the result
    rsp1_ready = 1'b0;
    issue(1, 32'd7, 32'd9, ALU_ADD, 32'd16, 1'b0, 1'b0, w);
    @(negedge clk);
    check("t5_busy_before", {31'b0, busy}, 32'd1);
    check("t5_done1_before", {24'b0, done1}, 32'd2);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd22; req0_op = ALU_ADD;
    req1_valid = 1'b1; req1_a = 32'd1;  req1_b = 32'd1;  req1_op = ALU_ADD;
    #1;
    check("t5_rsp1_valid_drop", {31'b0, rsp1_valid}, 32'd0);
    check("t5_busy_drop", {31'b0, busy}, 32'd0);
    check("t5_done1_reset", {24'b0, done1}, 32'd0);
    check("t5_req0_ready_in_rst", {31'b0, req0_ready}, 32'd0);
    check("t5_req1_ready_in_rst", {31'b0, req1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    q.push_back('{0, 32'd42});
    #1;
    check("t5_req0_wins", {31'b0, req0_ready}, 32'd1);
    check("t5_req1_loses", {31'b0, req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("t5_done0", {24'b0, done0}, 32'd1);

    // completion counter wrap
    do_reset();
    rsp0_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      issue(0, i, 32'd1, ALU_ADD, i + 1, 1'b1, 1'b1, w);
      if (i == 254) check("t6_done0_max", {24'b0, done0}, 32'd255);
    end
    check("t6_done0_wrap", {24'b0, done0}, 32'd0);

    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
